// File: rtl/player_position_if.sv
// Signal bundle between the jump-motion controller / key inputs and the player position block.
// The block itself uses the slave modport; the driving side uses master.
interface player_position_if;
    logic       frame_clk;
    logic [9:0] Ball_Y_Motion;
    logic       Jmp;
    logic       key_left;
    logic       key_right;
    logic [9:0] Ball_X_Pos;
    logic [9:0] Ball_Y_Pos;
    logic       airborne;
    logic       landed;
    logic       frame_tick;

    modport master (
        output frame_clk, Ball_Y_Motion, Jmp, key_left, key_right,
        input  Ball_X_Pos, Ball_Y_Pos, airborne, landed, frame_tick
    );

    modport slave (
        input  frame_clk, Ball_Y_Motion, Jmp, key_left, key_right,
        output Ball_X_Pos, Ball_Y_Pos, airborne, landed, frame_tick
    );
endinterface

// File: rtl/player_position.sv
// Per-frame X/Y integrator for the player sprite with GROUND/RISING/FALLING tracking and a landing pulse.
// Define PLAYER_FALL_EN to make a dropped Jmp fall at FALL_STEP per frame instead of snapping to ground.
module player_position #(
    parameter int X_START   = 320,
    parameter int Y_GROUND  = 400,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int X_STEP    = 2,
    parameter int FALL_STEP = 4
) (
    input  logic             clk,
    input  logic             Reset,
    player_position_if.slave pif
);
    // state   | meaning
    // GROUND  | resting at Y_GROUND
    // RISING  | moving up under jump control
    // FALLING | moving down toward Y_GROUND
    typedef enum logic [1:0] {GROUND, RISING, FALLING} state_t;

`ifdef PLAYER_FALL_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif
    // Without the fall feature a dropped Jmp takes one step spanning the whole screen: a snap to ground.
    localparam int DROP_STEP = FALL_EN ? FALL_STEP : Y_GROUND;

    localparam logic signed [10:0] X_STEP_S   = 11'(X_STEP);
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S    = 11'(Y_MIN);
    localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
    localparam logic signed [10:0] DROP_S     = 11'(DROP_STEP);
    localparam logic [9:0]         X_START_U  = 10'(X_START);
    localparam logic [9:0]         X_MIN_U    = 10'(X_MIN);
    localparam logic [9:0]         X_MAX_U    = 10'(X_MAX);
    localparam logic [9:0]         Y_MIN_U    = 10'(Y_MIN);
    localparam logic [9:0]         Y_GROUND_U = 10'(Y_GROUND);

    state_t            state;
    logic              sync1, sync2, hist;
    logic              tick_r, landed_r, airborne_r;
    logic [9:0]        x_pos, y_pos;
    logic signed [10:0] x_ext, x_left, x_right, y_ext, y_step, y_drop;
    logic [9:0]        x_next, y_clamped, y_dropped;
    logic              motion_neg, motion_zero;

    assign motion_neg  = pif.Ball_Y_Motion[9];
    assign motion_zero = (pif.Ball_Y_Motion == 10'd0);

    always_comb begin
        x_ext   = signed'({1'b0, x_pos});
        x_left  = x_ext - X_STEP_S;
        x_right = x_ext + X_STEP_S;
        x_next  = x_pos;
        if (pif.key_left && !pif.key_right)
            x_next = (x_left < X_MIN_S) ? X_MIN_U : x_left[9:0];
        else if (pif.key_right && !pif.key_left)
            x_next = (x_right > X_MAX_S) ? X_MAX_U : x_right[9:0];

        y_ext  = signed'({1'b0, y_pos});
        y_step = y_ext + signed'({pif.Ball_Y_Motion[9], pif.Ball_Y_Motion});
        if (y_step < Y_MIN_S)
            y_clamped = Y_MIN_U;
        else if (y_step > Y_GROUND_S)
            y_clamped = Y_GROUND_U;
        else
            y_clamped = y_step[9:0];

        y_drop    = y_ext + DROP_S;
        y_dropped = (y_drop > Y_GROUND_S) ? Y_GROUND_U : y_drop[9:0];
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            // History at 1 so a frame_clk already high at release is not taken as an edge.
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            hist       <= 1'b1;
            tick_r     <= 1'b0;
            landed_r   <= 1'b0;
            airborne_r <= 1'b0;
            state      <= GROUND;
            x_pos      <= X_START_U;
            y_pos      <= Y_GROUND_U;
        end else begin
            sync1    <= pif.frame_clk;
            sync2    <= sync1;
            hist     <= sync2;
            tick_r   <= sync2 & ~hist;
            landed_r <= 1'b0;
            if (tick_r) begin
                x_pos <= x_next;
                if (pif.Jmp) begin
                    case (state)
                        GROUND: begin
                            if (motion_neg) begin
                                state      <= RISING;
                                airborne_r <= 1'b1;
                                y_pos      <= y_clamped;
                            end else begin
                                y_pos <= Y_GROUND_U;
                            end
                        end
                        RISING: begin
                            if (motion_neg) begin
                                y_pos <= y_clamped;
                            end else if (!motion_zero) begin
                                state <= FALLING;
                                y_pos <= y_clamped;
                            end
                        end
                        FALLING: begin
                            y_pos <= y_clamped;
                            if (motion_neg) begin
                                state <= RISING;
                            end else if (y_clamped == Y_GROUND_U) begin
                                state      <= GROUND;
                                airborne_r <= 1'b0;
                                landed_r   <= 1'b1;
                            end
                        end
                        default: begin
                            state      <= GROUND;
                            airborne_r <= 1'b0;
                            y_pos      <= Y_GROUND_U;
                        end
                    endcase
                end else if (state != GROUND) begin
                    y_pos <= y_dropped;
                    if (y_dropped == Y_GROUND_U) begin
                        state      <= GROUND;
                        airborne_r <= 1'b0;
                        landed_r   <= 1'b1;
                    end else begin
                        state <= FALLING;
                    end
                end
            end
        end
    end

    assign pif.Ball_X_Pos = x_pos;
    assign pif.Ball_Y_Pos = y_pos;
    assign pif.airborne   = airborne_r;
    assign pif.landed     = landed_r;
    assign pif.frame_tick = tick_r;
endmodule

// File: tb/tb_player_position.sv
// Scoreboard bench for player_position: default instance plus a Y_MIN=350 instance share one stimulus stream.
// Expected positions come from a frame-level model; a monitor compares after every frame_tick.
module tb_player_position;
    localparam int GND = 0, RIS = 1, FAL = 2;

    typedef struct {
        int x;
        int y;
        bit air;
        bit land;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    player_position_if ifa ();
    player_position_if ifb ();

    player_position dut_a (.clk(clk), .Reset(Reset), .pif(ifa));
    player_position #(.Y_MIN(350)) dut_b (.clk(clk), .Reset(Reset), .pif(ifb));

    int   nvec = 0;
    int   nbad = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   mx[2], my[2], ms[2];
    int   ymin[2] = '{0, 350};
    bit   cur_j, cur_l, cur_r;
    int   cur_mot;
    int   land_cnt[2] = '{0, 0};
    bit   prev_land[2] = '{0, 0};
    int   jump_seq[30] = '{-8, -8, -6, -6, -6, -6, -5, -5, -4, -4, -3, -3, -2, -2, 0, 0,
                           2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6, 6, 8, 8};

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 320;
            my[i] = 400;
            ms[i] = GND;
        end
    endtask

    task automatic model_tick(input int i);
        exp_t e;
        int   ny;
        bit   land;
        land = 1'b0;
        if (cur_l && !cur_r) mx[i] = clampi(mx[i] - 2, 0, 639);
        else if (cur_r && !cur_l) mx[i] = clampi(mx[i] + 2, 0, 639);
        if (cur_j) begin
            ny = clampi(my[i] + cur_mot, ymin[i], 400);
            if (ms[i] == GND) begin
                if (cur_mot < 0) begin ms[i] = RIS; my[i] = ny; end
                else my[i] = 400;
            end else if (ms[i] == RIS) begin
                if (cur_mot != 0) my[i] = ny;
                if (cur_mot > 0) ms[i] = FAL;
            end else begin
                my[i] = ny;
                if (cur_mot < 0) ms[i] = RIS;
                else if (ny == 400) begin ms[i] = GND; land = 1'b1; end
            end
        end else if (ms[i] != GND) begin
`ifdef PLAYER_FALL_EN
            my[i] = clampi(my[i] + 4, 0, 400);
`else
            my[i] = 400;
`endif
            if (my[i] == 400) begin ms[i] = GND; land = 1'b1; end
            else ms[i] = FAL;
        end
        e.x = mx[i]; e.y = my[i]; e.air = (ms[i] != GND); e.land = land;
        if (i == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic check_out(input int i, input int x, input int y, input bit air, input bit land);
        exp_t e;
        nvec++;
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
            nbad++;
            $display("FAIL spurious_tick dut%0d: got tick with no expected frame (x=%0d y=%0d)", i, x, y);
        end else begin
            e = (i == 0) ? qa.pop_front() : qb.pop_front();
            if (x != e.x || y != e.y || air != e.air || land != e.land) begin
                nbad++;
                $display("FAIL frame_update dut%0d: got x=%0d y=%0d air=%0d land=%0d, want x=%0d y=%0d air=%0d land=%0d",
                         i, x, y, air, land, e.x, e.y, e.air, e.land);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (ifa.frame_tick) begin
            @(negedge clk);
            check_out(0, ifa.Ball_X_Pos, ifa.Ball_Y_Pos, ifa.airborne, ifa.landed);
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifb.frame_tick) begin
            @(negedge clk);
            check_out(1, ifb.Ball_X_Pos, ifb.Ball_Y_Pos, ifb.airborne, ifb.landed);
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifa.landed) begin
            nvec++; land_cnt[0]++;
            if (prev_land[0]) begin nbad++; $display("FAIL landed_width dut0: high 2 cycles, want 1"); end
        end
        if (ifb.landed) begin
            nvec++; land_cnt[1]++;
            if (prev_land[1]) begin nbad++; $display("FAIL landed_width dut1: high 2 cycles, want 1"); end
        end
        prev_land[0] = ifa.landed;
        prev_land[1] = ifb.landed;
    end

    task automatic set_in(input bit j, input int mot, input bit l, input bit r);
        cur_j = j; cur_mot = mot; cur_l = l; cur_r = r;
        ifa.Jmp = j; ifa.Ball_Y_Motion = 10'(mot); ifa.key_left = l; ifa.key_right = r;
        ifb.Jmp = j; ifb.Ball_Y_Motion = 10'(mot); ifb.key_left = l; ifb.key_right = r;
    endtask

    // One frame: frame_clk high for `hold` cycles; the tick must appear once, in the 3rd cycle.
    task automatic do_tick(input int hold);
        int nt, first;
        model_tick(0);
        model_tick(1);
        @(negedge clk);
        ifa.frame_clk = 1'b1; ifb.frame_clk = 1'b1;
        nt = 0; first = 0;
        for (int c = 1; c <= hold + 5; c++) begin
            @(negedge clk);
            if (c == hold) begin ifa.frame_clk = 1'b0; ifb.frame_clk = 1'b0; end
            if (ifa.frame_tick) begin nt++; if (first == 0) first = c; end
        end
        nvec++;
        if (nt != 1 || first != 3) begin
            nbad++;
            $display("FAIL tick_timing: got %0d ticks first at cycle %0d, want 1 tick at cycle 3", nt, first);
        end
    endtask

    task automatic rnd_tick();
        do_tick(int'($urandom_range(1, 6)));
    endtask

    task automatic check_reset();
        nvec++;
        if (ifa.Ball_X_Pos != 10'd320 || ifa.Ball_Y_Pos != 10'd400 || ifa.airborne || ifa.landed || ifa.frame_tick) begin
            nbad++;
            $display("FAIL reset_state dut0: got x=%0d y=%0d air=%0d land=%0d tick=%0d, want 320 400 0 0 0",
                     ifa.Ball_X_Pos, ifa.Ball_Y_Pos, ifa.airborne, ifa.landed, ifa.frame_tick);
        end
        nvec++;
        if (ifb.Ball_X_Pos != 10'd320 || ifb.Ball_Y_Pos != 10'd400 || ifb.airborne || ifb.landed || ifb.frame_tick) begin
            nbad++;
            $display("FAIL reset_state dut1: got x=%0d y=%0d air=%0d land=%0d tick=%0d, want 320 400 0 0 0",
                     ifb.Ball_X_Pos, ifb.Ball_Y_Pos, ifb.airborne, ifb.landed, ifb.frame_tick);
        end
    endtask

    task automatic climb_to_340();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, (k == 7) ? -4 : -8, 1'b0, 1'b0);
            rnd_tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int l0, l1, nt;
        Reset = 1'b1;
        ifa.frame_clk = 1'b1; ifb.frame_clk = 1'b1;
        set_in(1'b0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset();
        Reset = 1'b0;
        nt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifa.frame_tick || ifb.frame_tick) nt++;
        end
        nvec++;
        if (nt != 0) begin
            nbad++;
            $display("FAIL release_high_frame_clk: got %0d ticks, want 0", nt);
        end
        ifa.frame_clk = 1'b0; ifb.frame_clk = 1'b0;
        repeat (4) @(negedge clk);

        // Full jump; dut_b sees the same sequence against a 350 ceiling.
        l0 = land_cnt[0]; l1 = land_cnt[1];
        for (int k = 0; k < 30; k++) begin
            set_in(1'b1, jump_seq[k], 1'b0, 1'b0);
            do_tick((k == 0) ? 10 : int'($urandom_range(1, 6)));
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (land_cnt[0] - l0 != 1) begin nbad++; $display("FAIL jump_landings dut0: got %0d, want 1", land_cnt[0] - l0); end
        nvec++;
        if (land_cnt[1] - l1 != 1) begin nbad++; $display("FAIL jump_landings dut1: got %0d, want 1", land_cnt[1] - l1); end

        // Horizontal sweep to both edges.
        for (int k = 0; k < 5; k++) begin set_in(1'b0, 0, 1'b0, 1'b1); rnd_tick(); end
        while (mx[0] < 638) begin set_in(1'b0, 0, 1'b0, 1'b1); rnd_tick(); end
        repeat (2) begin set_in(1'b0, 0, 1'b0, 1'b1); rnd_tick(); end
        repeat (2) begin set_in(1'b0, 0, 1'b1, 1'b1); rnd_tick(); end
        while (mx[0] > 1) begin set_in(1'b0, 0, 1'b1, 1'b0); rnd_tick(); end
        repeat (2) begin set_in(1'b0, 0, 1'b1, 1'b0); rnd_tick(); end

        // Reset mid-jump, then jump again.
        climb_to_340();
        @(negedge clk);
        Reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset();
        @(negedge clk);
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin set_in(1'b1, -8, 1'b0, 1'b1); rnd_tick(); end
        set_in(1'b0, 0, 1'b0, 1'b0); rnd_tick();

        // Jmp dropped while rising at 340.
        climb_to_340();
        for (int k = 0; k < 16; k++) begin set_in(1'b0, 0, 1'b0, 1'b0); rnd_tick(); end

        // Random traffic, with occasional full-range motion to hit the clamps.
        for (int k = 0; k < 250; k++) begin
            int mot;
            if ($urandom_range(0, 7) == 0) mot = int'($signed(10'($urandom_range(0, 1023))));
            else mot = int'($urandom_range(0, 20)) - 10;
            set_in($urandom_range(0, 3) != 0, mot, 1'($urandom), 1'($urandom));
            rnd_tick();
        end

        repeat (6) @(negedge clk);
        nvec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            nbad++;
            $display("FAIL pending_frames: got %0d/%0d unchecked, want 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/player_position.md
Name: player_position

Overview:
- Downstream consumer of the jump-motion controller; sits between it and the sprite/VGA draw logic.
- Once per video frame, integrates the signed 10-bit vertical step (Ball_Y_Motion, gated by Jmp) and the left/right key inputs into the player's X/Y position.
- Clamps the position to the screen and ground and tracks GROUND / RISING / FALLING state.
- Flags landing with a one-cycle pulse for score and sound logic.

Parameters:
- X_START, 320: X position at reset.
- Y_GROUND, 400: ground Y (largest legal Y); Y position at reset.
- X_MIN, 0: leftmost legal X.
- X_MAX, 639: rightmost legal X.
- Y_MIN, 0: ceiling (smallest legal Y).
- X_STEP, 2: horizontal pixels moved per frame tick.
- FALL_STEP, 4: pixels fallen per tick in fall mode (only used with the optional feature).

Ports:
- clk  in  1  system clock
- Reset  in  1  reset
- frame_clk  in  1  frame strobe (vsync-derived), asynchronous to clk
- Ball_Y_Motion  in  10  signed two's-complement Y step per tick from the jump controller
- Jmp  in  1  jump controller active (high from first jump state until rest)
- key_left  in  1  left key held
- key_right  in  1  right key held
- Ball_X_Pos  out  10  current X, unsigned
- Ball_Y_Pos  out  10  current Y, unsigned
- airborne  out  1  high in RISING or FALLING
- landed  out  1  one-clk pulse on return to ground
- frame_tick  out  1  one-clk pulse per frame_clk rising edge

Behaviour:
- Reset: Reset, asynchronous, active-high; clock clk. During reset: Ball_X_Pos=X_START, Ball_Y_Pos=Y_GROUND, state GROUND, airborne=0, landed=0, frame_tick=0.
- Reset also sets all three frame_clk sync/history flops to 1, so no spurious tick occurs if frame_clk is high when reset releases.
- Tick generation: frame_clk passes through a 2-flop synchroniser plus a history flop. frame_tick is registered and high for exactly one clk when sync2=1 and hist=0.
  - Latency: tick is high in the 3rd clk cycle after frame_clk is first sampled high.
  - Positions, state, airborne and landed update on the clk edge that ends the tick cycle. They hold in all other cycles.
- X update per tick:
  - left only: X-X_STEP, floored at X_MIN.
  - right only: X+X_STEP, capped at X_MAX.
  - both or neither: hold.
  - Compute in 11-bit signed arithmetic; no wrap-around at 0 or 1023.
- Y update per tick: if Jmp=1, nextY = Y + sext(Ball_Y_Motion) in 11-bit signed, then clamped to [Y_MIN, Y_GROUND]. If Jmp=0, see FSM.
- FSM, evaluated per tick:
  - GROUND: Jmp=1 and motion<0 -> RISING, apply step. Jmp=1 and motion>=0 -> stay, Y held at Y_GROUND.
  - RISING: motion<0 -> stay. motion==0 -> stay, hold Y. motion>0 -> FALLING, apply step.
  - FALLING: after the step, if clamped nextY==Y_GROUND -> GROUND and landed=1 for one clk; else stay. A negative motion while FALLING -> RISING.
  - Jmp=0 while RISING/FALLING (without the feature): Y snaps to Y_GROUND, state -> GROUND, landed pulses.
- airborne = (state!=GROUND), registered.
- Simultaneous events: X and Y update in the same tick, independently.
- landed never pulses twice for one landing.
- Reset mid-jump returns to the reset values immediately; the first tick after release behaves as from GROUND.

Optional Feature:
- Macro PLAYER_FALL_EN.
- Defined: if Jmp drops while airborne, state goes to FALLING and Y increases by FALLING_STEP... specifically FALL_STEP per tick until it reaches Y_GROUND (clamped), then GROUND plus a landed pulse. Jmp rising during the fall resumes normal integration.
- Undefined: the snap-to-ground behaviour above. FALL_STEP is unused.

Test Plan:
- Full jump: from (320,400), Jmp=1 with the 30-tick sequence -8,-8,-6x4,-5,-5,-4,-4,-3,-3,-2,-2,0,0,2,2,3,3,4,4,5,5,6x4,8,8 -> Y reaches min 332 after 14 ticks, returns to 400; airborne high during, landed pulses exactly once.
- Ceiling clamp: Y_MIN=350, same sequence -> Y floors at 350 (never below), then descends and clamps at 400.
- Horizontal: key_right held 5 ticks from 320 -> 330; X at 638 plus right -> 639 then holds; both keys -> X unchanged; X at 1 plus left -> 0.
- Tick timing: frame_clk high for 10 clk -> exactly one frame_tick, 3rd cycle after sampling. Reset released with frame_clk high -> no tick until next rising edge.
- Reset mid-jump at Y=340 -> outputs 320/400, airborne=0 during reset; next jump proceeds normally.
- Jmp dropped at Y=340 while RISING: without PLAYER_FALL_EN -> Y=400 next tick plus landed. With it -> 344, 348, ... 400 (15 ticks), then landed.
